// File: rtl/flow_table_lookup.sv
// Wildcard flow table: sequential priority scan (index 0 first), one entry per cycle.
// Latency: hit at index i acks 2+i cycles after req; miss acks 1+NENTRY cycles after; req while busy is dropped.
module flow_table_lookup #(
    parameter int NPORT  = 4,
    parameter int NENTRY = 8,
    parameter int AW     = 3,
    parameter int KEY_W  = 116
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             of_lookup_req,
    input  logic [KEY_W-1:0] of_lookup_data,
    output logic             of_lookup_ack,
    output logic             of_lookup_err,
    output logic [NPORT-1:0] of_lookup_fwd_port,
    output logic             lookup_busy,
    input  logic             tbl_wr_en,
    input  logic [AW-1:0]    tbl_wr_addr,
    input  logic             tbl_wr_valid,
    input  logic [KEY_W-1:0] tbl_wr_key,
    input  logic [KEY_W-1:0] tbl_wr_mask,
    input  logic [NPORT-1:0] tbl_wr_port,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
);
    typedef enum logic {S_IDLE = 1'b0, S_SEARCH = 1'b1} state_t;

    localparam logic [31:0]   CNT_MAX  = 32'hFFFF_FFFF;
    localparam logic [AW-1:0] LAST_IDX = AW'(NENTRY - 1);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [KEY_W-1:0]  r_tbl_key  [NENTRY];
    logic [KEY_W-1:0]  r_tbl_mask [NENTRY];
    logic [NPORT-1:0]  r_tbl_port [NENTRY];
    logic [NENTRY-1:0] r_tbl_valid;

    logic [KEY_W-1:0]  r_key_q;
    logic [AW-1:0]     r_idx;
    logic              r_ack;
    logic              r_err;
    logic [NPORT-1:0]  r_fwd_port;
    logic              r_busy;
    logic [31:0]       r_hit_count;
    logic [31:0]       r_miss_count;

    logic              w_wr;
    logic              w_match;
    logic              w_last;
    logic              w_accept;
    logic              w_done;
    logic              w_hit;
    logic              w_miss;

    assign w_wr    = tbl_wr_en && (32'(tbl_wr_addr) < 32'(NENTRY));
    assign w_match = r_tbl_valid[r_idx] &&
                     (((r_key_q ^ r_tbl_key[r_idx]) & r_tbl_mask[r_idx]) == '0);
    assign w_last  = (r_idx == LAST_IDX);

    // Table storage; only valid bits need a reset, key/mask/port are don't-care while invalid.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_tbl_valid <= '0;
        end else if (w_wr) begin
            r_tbl_valid[tbl_wr_addr] <= tbl_wr_valid;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr) begin
            r_tbl_key[tbl_wr_addr]  <= tbl_wr_key;
            r_tbl_mask[tbl_wr_addr] <= tbl_wr_mask;
            r_tbl_port[tbl_wr_addr] <= tbl_wr_port;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (of_lookup_req) w_state_nxt = S_SEARCH;
            S_SEARCH: if (w_match || w_last) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept = 1'b0;
        w_done   = 1'b0;
        w_hit    = 1'b0;
        w_miss   = 1'b0;
        case (r_state)
            S_IDLE:   w_accept = of_lookup_req;
            S_SEARCH: begin
                w_done = w_match || w_last;
                w_hit  = w_match;
                w_miss = !w_match && w_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_key_q      <= '0;
            r_idx        <= '0;
            r_ack        <= 1'b0;
            r_err        <= 1'b0;
            r_fwd_port   <= '0;
            r_busy       <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_ack <= w_done;
            r_err <= w_miss;
            if (w_accept) begin
                r_key_q <= of_lookup_data;
                r_idx   <= '0;
                r_busy  <= 1'b1;
            end else if (w_done) begin
                r_busy  <= 1'b0;
            end else if (r_state == S_SEARCH) begin
                r_idx   <= r_idx + 1'b1;
            end
            // fwd_port holds between acks so late readers still see the last result
            if (w_hit) begin
                r_fwd_port <= r_tbl_port[r_idx];
            end else if (w_miss) begin
                r_fwd_port <= '0;
            end
            if (w_hit && (r_hit_count != CNT_MAX)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss && (r_miss_count != CNT_MAX)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign of_lookup_ack      = r_ack;
    assign of_lookup_err      = r_err;
    assign of_lookup_fwd_port = r_fwd_port;
    assign lookup_busy        = r_busy;
    assign hit_count          = r_hit_count;
    assign miss_count         = r_miss_count;

endmodule
